// File: rtl/lvds_pingpong_buf.sv
// Two-bank ping-pong line buffer between an LVDS capture stage and a ready/valid reader.
// A rising edge on data_switch closes the current line and hands it to the read side.
module lvds_pingpong_buf #(
    parameter int DW    = 16,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lvds_data_valid,
    input  logic [DW-1:0] lvds_wr_data,
    input  logic          data_switch,
    input  logic          stat_clr,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          rd_busy,
    output logic [15:0]   line_cnt,
    output logic [7:0]    miss_cnt,
    output logic          overflow_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    state_t          state_q, state_d;
    logic            fire_q;
    logic            fire_edge, swap, miss_evt, ovf_evt, is_last;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_len_q, rd_idx_q, rd_idx_d;
    logic            wr_bank_q;
    logic [15:0]     line_cnt_q;
    logic [7:0]      miss_cnt_q;
    logic            overflow_q;

    logic            mem_we, mem_wr_bank, mem_re;
    logic [AW-1:0]   mem_wr_addr, mem_rd_addr;
    logic [DW-1:0]   mem [2*DEPTH];
    logic [DW-1:0]   rd_data_q;

    assign fire_edge = data_switch & ~fire_q;
    assign swap      = fire_edge & (state_q == IDLE);
    assign miss_evt  = fire_edge & (state_q != IDLE);
    assign ovf_evt   = ~fire_edge & lvds_data_valid & (wr_ptr_q == FULL);
    assign is_last   = ((rd_idx_q + (AW+1)'(1)) == rd_len_q);

    // A word arriving with the edge opens the new line, so it lands at address 0
    // of whichever bank is the write bank after the edge.
    always_comb begin
        mem_we      = 1'b0;
        mem_wr_bank = wr_bank_q;
        mem_wr_addr = wr_ptr_q[AW-1:0];
        wr_ptr_d    = wr_ptr_q;
        if (fire_edge) begin
            mem_wr_bank = swap ? ~wr_bank_q : wr_bank_q;
            mem_wr_addr = '0;
            mem_we      = lvds_data_valid;
            wr_ptr_d    = lvds_data_valid ? (AW+1)'(1) : '0;
        end else if (lvds_data_valid && (wr_ptr_q != FULL)) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
    end

    // The RAM output register only reloads on FETCH or on an accepted non-last
    // word, which keeps rd_data stable through stalls and gives bubble-free prefetch.
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        mem_re      = 1'b0;
        mem_rd_addr = rd_idx_q[AW-1:0];
        case (state_q)
            IDLE: begin
                if (swap && (wr_ptr_q != '0)) begin
                    state_d  = FETCH;
                    rd_idx_d = '0;
                end
            end
            FETCH: begin
                mem_re  = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (rd_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        rd_idx_d    = rd_idx_q + (AW+1)'(1);
                        mem_re      = 1'b1;
                        mem_rd_addr = rd_idx_q[AW-1:0] + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fire_q     <= 1'b0;
            wr_ptr_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_len_q   <= '0;
            rd_idx_q   <= '0;
            line_cnt_q <= '0;
            miss_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fire_q   <= data_switch;
            wr_ptr_q <= wr_ptr_d;
            rd_idx_q <= rd_idx_d;
            if (swap) begin
                rd_len_q   <= wr_ptr_q;
                wr_bank_q  <= ~wr_bank_q;
                line_cnt_q <= line_cnt_q + 16'd1;
            end
            if (ovf_evt)
                overflow_q <= 1'b1;
            else if (stat_clr)
                overflow_q <= 1'b0;
            if (miss_evt)
                miss_cnt_q <= stat_clr ? 8'd1 : ((miss_cnt_q == 8'hFF) ? 8'hFF : miss_cnt_q + 8'd1);
            else if (stat_clr)
                miss_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[{mem_wr_bank, mem_wr_addr}] <= lvds_wr_data;
    end

    // Reads always target the bank opposite the write bank.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data_q <= '0;
        else if (mem_re)
            rd_data_q <= mem[{~wr_bank_q, mem_rd_addr}];
    end

    assign rd_valid      = (state_q == STREAM);
    assign rd_last       = rd_valid & is_last;
    assign rd_busy       = (state_q != IDLE);
    assign rd_data       = rd_data_q;
    assign line_cnt      = line_cnt_q;
    assign miss_cnt      = miss_cnt_q;
    assign overflow_flag = overflow_q;
endmodule

// File: tb/tb_lvds_pingpong_buf.sv
// Randomized and directed bench for lvds_pingpong_buf against a line-level queue model.
module tb_lvds_pingpong_buf;
    localparam int DW    = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          lvds_data_valid;
    logic [DW-1:0] lvds_wr_data;
    logic          data_switch;
    logic          stat_clr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_busy;
    logic [15:0]   line_cnt;
    logic [7:0]    miss_cnt;
    logic          overflow_flag;

    lvds_pingpong_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .lvds_data_valid(lvds_data_valid), .lvds_wr_data(lvds_wr_data),
        .data_switch(data_switch), .stat_clr(stat_clr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_busy(rd_busy),
        .line_cnt(line_cnt), .miss_cnt(miss_cnt), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    // Model: words of the line being captured, words of the line being read out.
    int          cur_q[$];
    int          rd_q[$];
    bit          busy_m;
    bit          ovf_m;
    int          miss_m;
    logic [15:0] line_m;
    bit          prev_sw;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acc, edge_m, start_rd, ovf_evt, miss_evt;
        acc = 1'b0;
        if (!rst) begin
            check("rd_busy", rd_busy, busy_m);
            if (!busy_m) check("valid_when_idle", rd_valid, 1'b0);
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    check("extra_word", rd_valid, 1'b0);
                end else begin
                    check("rd_data", rd_data, rd_q[0]);
                    check("rd_last", rd_last, rd_q.size() == 1);
                    acc = rd_ready;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            cur_q.delete(); rd_q.delete();
            busy_m = 0; ovf_m = 0; miss_m = 0; line_m = '0; prev_sw = 0;
            check("rst_valid", rd_valid, 1'b0);
            check("rst_last", rd_last, 1'b0);
            check("rst_busy", rd_busy, 1'b0);
            check("rst_data", rd_data, 0);
            check("rst_line", line_cnt, 0);
            check("rst_miss", miss_cnt, 0);
            check("rst_ovf", overflow_flag, 1'b0);
            return;
        end
        edge_m = data_switch && !prev_sw;
        start_rd = 0; ovf_evt = 0; miss_evt = 0;
        if (edge_m) begin
            if (!busy_m) begin
                line_m = line_m + 16'd1;
                if (cur_q.size() > 0) begin
                    rd_q = cur_q;
                    start_rd = 1;
                end
            end else begin
                miss_evt = 1;
            end
            cur_q.delete();
            if (lvds_data_valid) cur_q.push_back(int'(lvds_wr_data));
        end else if (lvds_data_valid) begin
            if (cur_q.size() < DEPTH) cur_q.push_back(int'(lvds_wr_data));
            else ovf_evt = 1;
        end
        if (acc) begin
            void'(rd_q.pop_front());
            if (rd_q.size() == 0) busy_m = 0;
        end
        if (start_rd) busy_m = 1;
        if (ovf_evt) ovf_m = 1;
        else if (stat_clr) ovf_m = 0;
        if (miss_evt) miss_m = stat_clr ? 1 : ((miss_m == 255) ? 255 : miss_m + 1);
        else if (stat_clr) miss_m = 0;
        prev_sw = data_switch;
        check("line_cnt", line_cnt, line_m);
        check("miss_cnt", miss_cnt, miss_m);
        check("overflow_flag", overflow_flag, ovf_m);
    endtask

    task automatic wr_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            lvds_data_valid = 1'b1;
            lvds_wr_data    = DW'(base + i);
            tick();
        end
        lvds_data_valid = 1'b0;
    endtask

    task automatic fire();
        data_switch = 1'b1;
        tick();
        data_switch = 1'b0;
        lvds_data_valid = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        rd_ready = 1'b1;
        lvds_data_valid = 1'b0;
        for (int i = 0; i < 3 * DEPTH + 20 && busy_m; i++) tick();
        check({name, "_drain_timeout"}, rd_busy, 1'b0);
        $display("line %s read out: line_cnt=%0d miss_cnt=%0d overflow=%0d", name, line_cnt, miss_cnt, overflow_flag);
    endtask

    initial begin
        rst = 1'b1; lvds_data_valid = 1'b0; lvds_wr_data = '0;
        data_switch = 1'b0; stat_clr = 1'b0; rd_ready = 1'b0;
        busy_m = 0; ovf_m = 0; miss_m = 0; line_m = '0; prev_sw = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Five words, single flush, reader always ready.
        rd_ready = 1'b1;
        wr_words(5, 1);
        fire();
        drain("basic5");
        check("basic5_line_cnt", line_cnt, 1);

        // Eight words with a reader stalling every other cycle.
        wr_words(8, 16'h0100);
        fire();
        for (int i = 0; i < 100 && busy_m; i++) begin
            rd_ready = i[0];
            tick();
        end
        drain("stall8");

        // Overfill the bank; only DEPTH words survive.
        wr_words(DEPTH + 3, 16'h1000);
        check("ovf_set", overflow_flag, 1'b1);
        fire();
        drain("overflow");
        stat_clr = 1'b1; tick(); stat_clr = 1'b0; tick();
        check("ovf_cleared", overflow_flag, 1'b0);

        // Edge during a long readout is a miss; the interrupted line is discarded.
        wr_words(100, 16'h2000);
        fire();
        rd_ready = 1'b1;
        wr_words(10, 16'h3000);
        fire();
        check("miss_one", miss_cnt, 1);
        check("miss_line_held", line_cnt, 4);
        wr_words(6, 16'h4000);
        drain("miss_first");
        fire();
        drain("miss_second");

        // Word coincident with the edge starts the next line.
        wr_words(3, 16'h5000);
        lvds_data_valid = 1'b1; lvds_wr_data = 16'hABCD;
        fire();
        drain("coincident_a");
        fire();
        drain("coincident_b");

        // Edge with nothing captured: counts a line, no readout.
        begin
            logic [15:0] lc;
            lc = line_cnt;
            fire();
            tick();
            check("empty_line_cnt", line_cnt, lc + 16'd1);
            check("empty_no_busy", rd_busy, 1'b0);
        end

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            lvds_data_valid = ($urandom_range(0, 2) != 0);
            lvds_wr_data    = DW'($urandom);
            if ($urandom_range(0, 29) == 0) data_switch = ~data_switch;
            stat_clr = ($urandom_range(0, 49) == 0);
            rd_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        stat_clr = 1'b0; data_switch = 1'b0;
        drain("random");

        // Reset in the middle of a readout.
        wr_words(50, 16'h6000);
        fire();
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        check("post_rst_valid", rd_valid, 1'b0);
        check("post_rst_line", line_cnt, 0);
        wr_words(4, 16'h7000);
        fire();
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/lvds_pingpong_buf.md
LVDS_PINGPONG_BUF -- requirements
Module: lvds_pingpong_buf

Interface
REQ-001 Parameter DW, 16, width of one LVDS data word.
REQ-002 Parameter DEPTH, 256, words per bank (power of two, >=4); AW = log2(DEPTH).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 lvds_data_valid  input  1  one word offered this cycle (from LVDS control stage).
REQ-006 lvds_wr_data  input  DW  word, sampled when lvds_data_valid=1.
REQ-007 data_switch  input  1  fire level; rising edge marks line boundary.
REQ-008 stat_clr  input  1  clears overflow_flag and miss_cnt.
REQ-009 rd_ready  input  1  downstream accepts rd_data this cycle.
REQ-010 rd_valid  output  1  rd_data valid.
REQ-011 rd_data  output  DW  buffered word.
REQ-012 rd_last  output  1  marks final word of a line, qualified by rd_valid.
REQ-013 rd_busy  output  1  read side not IDLE.
REQ-014 line_cnt  output  16  lines handed to read side, wraps 16'hFFFF->0.
REQ-015 miss_cnt  output  8  fire edges while read side busy, saturates at 8'hFF.
REQ-016 overflow_flag  output  1  sticky, write attempted with bank full.

Function
REQ-017 Two banks of DEPTH x DW, 1-cycle synchronous read; wr_bank selects write bank, rd_bank = !wr_bank.
REQ-018 Fire edge: fire_d registers data_switch; edge = data_switch & !fire_d; active in one cycle only.
REQ-019 Write (no edge): valid & wr_ptr<DEPTH -> write at wr_ptr, wr_ptr+1; wr_ptr is AW+1 bits.
REQ-020 Write with wr_ptr==DEPTH -> word dropped, overflow_flag<=1, wr_ptr held.
REQ-021 Edge & read side IDLE -> swap: rd_len<=wr_ptr, wr_bank toggles, line_cnt+1, read FSM leaves IDLE next cycle.
REQ-022 Edge & read side busy -> no swap, wr_ptr<=0 (current line discarded), miss_cnt+1 saturating, line_cnt unchanged.
REQ-023 Valid in edge cycle -> word belongs to new line: written at address 0 of post-edge write bank, wr_ptr<=1.
REQ-024 Read FSM states IDLE, FETCH, STREAM; IDLE->FETCH on swap with rd_len>0; swap with rd_len==0 stays IDLE, no words output.
REQ-025 FETCH: issue read of rd_ptr=0; next cycle -> STREAM with rd_valid=1.
REQ-026 STREAM: rd_data/rd_last stable while rd_valid & !rd_ready; on accept, if rd_last -> IDLE else next word presented next cycle (prefetch allowed, no bubble required but permitted).
REQ-027 rd_last=1 exactly when presented word index == rd_len-1; rd_len==DEPTH valid (full bank).
REQ-028 rd_busy = (state != IDLE); swap permitted in the same cycle the last word is accepted? No -- state must already be IDLE.
REQ-029 stat_clr: overflow_flag<=0, miss_cnt<=0; a same-cycle overflow or miss wins (flag/count = 1).
REQ-030 Bank write and read never target the same bank at the same time.

Reset
REQ-031 rst=1 at clk edge: rd_valid=0, rd_last=0, rd_busy=0, rd_data=0, line_cnt=0, miss_cnt=0, overflow_flag=0, wr_ptr=0, wr_bank=0, fire_d=0, state IDLE; bank contents not reset.
REQ-032 Reset mid-line or mid-readout aborts all activity; no rd_valid in the cycle after reset deassertion.

Verification
REQ-033 5 valid words 0x0001..0x0005, then fire edge, rd_ready=1 -> 5 words in order, rd_last on 0x0005, line_cnt=1.
REQ-034 rd_ready toggled 1/0 each cycle during 8-word readout -> rd_data held across stall cycles, no loss/duplication.
REQ-035 DEPTH+3 valid words, then edge -> overflow_flag=1, readout DEPTH words, rd_last on word DEPTH-1; stat_clr -> flag 0.
REQ-036 Second edge during 100-word readout -> miss_cnt=1, line_cnt unchanged, new line restarts at wr_ptr 0, readout finishes intact.
REQ-037 Valid 0xABCD coincident with edge -> 0xABCD excluded from flushed line, first word of following line.
REQ-038 Edge with zero words written -> line_cnt+1, rd_valid stays 0, rd_busy stays 0.
